// File: rtl/iic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : iic_pkg
//  Purpose  : Shared state encodings and bus constants for the I2C target
//             receiver (iic_slave_rx) and its input synchroniser.
//  Revision : 1.0  initial release
// ============================================================================
package iic_pkg;

  // Protocol FSM states; ACK states share one code path in the top module.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_REG       = 4'd3,
    ST_REG_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RACK      = 4'd8,
    ST_IGNORE    = 4'd9
  } state_t;

  // Level seen on sda during the ninth clock of a byte.
  localparam logic c_ACK  = 1'b0;
  localparam logic c_NACK = 1'b1;

  // Bits per byte; the counter reaches this value on the last data bit.
  localparam logic [3:0] c_BITS_PER_BYTE = 4'd8;

  // 7-bit address answered when the instantiating design does not override it.
  localparam logic [6:0] c_DEFAULT_SLAVE_ADDR = 7'h76;

endpackage : iic_pkg
`default_nettype wire

// File: rtl/iic_slave_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : iic_slave_rx_if
//  Purpose  : Register-side port of the I2C target: a write strobe with
//             address/data, a read pointer with its combinational read data,
//             and a transfer-in-progress flag.
//  Revision : 1.0  initial release
// ============================================================================
interface iic_slave_rx_if;

  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;

  // The I2C target drives the register bus and consumes read data.
  modport slave (
    output wr_en,
    output wr_addr,
    output wr_data,
    output rd_addr,
    output busy,
    input  rd_data
  );

  // The register file sees strobes and supplies data for rd_addr.
  modport master (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  rd_addr,
    input  busy,
    output rd_data
  );

endinterface : iic_slave_rx_if
`default_nettype wire

// File: rtl/iic_bus_sync.sv
`default_nettype none
// ============================================================================
//  Module   : iic_bus_sync
//  Purpose  : Brings scl/sda into the clk domain through a flop chain plus a
//             history flop, and derives one-cycle edge and START/STOP flags.
//  Revision : 1.0  initial release
// ============================================================================
module iic_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  scl,
  input  wire  sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_hist_q, scl_hist_d;
  logic                   sda_hist_q, sda_hist_d;
  logic                   w_scl_s;
  logic                   w_sda_rise;
  logic                   w_sda_fall;

  // Shift the pins into the synchroniser chains and remember last synced value.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
    scl_hist_d = scl_sync_q[SYNC_STAGES-1];
    sda_hist_d = sda_sync_q[SYNC_STAGES-1];
  end

  // Chains reset to the idle-bus level so reset release creates no edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end

  // Edge flags compare the synced level with its one-cycle history.
  always_comb begin
    w_scl_s    = scl_sync_q[SYNC_STAGES-1];
    sda_s      = sda_sync_q[SYNC_STAGES-1];
    scl_rise   =  w_scl_s & ~scl_hist_q;
    scl_fall   = ~w_scl_s &  scl_hist_q;
    w_sda_rise =  sda_s   & ~sda_hist_q;
    w_sda_fall = ~sda_s   &  sda_hist_q;
    start_det  = w_sda_fall & w_scl_s;
    stop_det   = w_sda_rise & w_scl_s;
  end

endmodule : iic_bus_sync
`default_nettype wire

// File: rtl/iic_slave_rx.sv
`default_nettype none
// ============================================================================
//  Module   : iic_slave_rx
//  Purpose  : I2C target at a fixed 7-bit address. Writes [addr+W][reg][data..]
//             emit one-cycle register write strobes; reads [addr+W][reg] Sr
//             [addr+R][data..] are served from a combinational read port.
//             SCL is only sampled, never stretched.
//  Revision : 1.0  initial release
// ============================================================================
module iic_slave_rx
  import iic_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = c_DEFAULT_SLAVE_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  wire                  clk,
  input  wire                  rst_n,
  input  wire                  scl,
  inout  wire                  sda,
  iic_slave_rx_if.slave        reg_if
);

  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;

  state_t     state_q,   state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q,   shift_d;    // first seven received bits
  logic [6:0] tx_q,      tx_d;       // remaining bits of the byte being read out
  logic       sda_oe_q,  sda_oe_d;   // 1 = pull sda low
  logic       rw_q,      rw_d;
  logic [7:0] rd_addr_q, rd_addr_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_en_q,   wr_en_d;
  logic       busy_q,    busy_d;

  logic [7:0] w_rx_byte;
  logic       w_last_bit;

  iic_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (scl),
    .sda       (sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // Open-drain output: only ever pull low or release.
  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  assign reg_if.wr_en   = wr_en_q;
  assign reg_if.wr_addr = wr_addr_q;
  assign reg_if.wr_data = wr_data_q;
  assign reg_if.rd_addr = rd_addr_q;
  assign reg_if.busy    = busy_q;

  // Completed byte as it stands on the 8th rising edge.
  always_comb begin
    w_rx_byte  = {shift_q, sda_s};
    w_last_bit = scl_rise && (bit_cnt_q == c_BITS_PER_BYTE - 4'd1);
  end

  // Next-state logic: bus conditions first, then per-state bit handling.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    sda_oe_d  = sda_oe_q;
    rw_d      = rw_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    busy_d    = busy_q;

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_IGNORE: begin
          sda_oe_d = 1'b0;
        end

        ST_ADDR, ST_REG, ST_WDATA: begin
          // Data is shifted only while fewer than eight bits are in, so a
          // stray scl pulse after the byte cannot produce a second strobe.
          if (scl_rise && bit_cnt_q < c_BITS_PER_BYTE) begin
            shift_d   = {shift_q[5:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
          if (w_last_bit) begin
            unique case (state_q)
              ST_ADDR: begin
                if (w_rx_byte[7:1] == SLAVE_ADDR && w_rx_byte[7:1] != 7'h00) begin
                  state_d = ST_ADDR_ACK;
                  rw_d    = w_rx_byte[0];
                end else begin
                  state_d   = ST_IGNORE;
                  bit_cnt_d = 4'd0;
                end
              end
              ST_REG: begin
                rd_addr_d = w_rx_byte;
                state_d   = ST_REG_ACK;
              end
              default: begin
                wr_en_d   = 1'b1;
                wr_addr_d = rd_addr_q;
                wr_data_d = w_rx_byte;
                state_d   = ST_WDATA_ACK;
              end
            endcase
          end
        end

        // bit_cnt==8: waiting for the fall that opens the ACK slot.
        // bit_cnt==0: ACK clock seen, the next fall closes the slot.
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          if (scl_fall && bit_cnt_q == c_BITS_PER_BYTE) begin
            sda_oe_d = (c_ACK == 1'b0);
          end else if (scl_rise && bit_cnt_q == c_BITS_PER_BYTE) begin
            bit_cnt_d = 4'd0;
          end else if (scl_fall && bit_cnt_q == 4'd0) begin
            sda_oe_d = 1'b0;
            unique case (state_q)
              ST_ADDR_ACK: begin
                if (rw_q) begin
                  state_d  = ST_RDATA;
                  tx_d     = reg_if.rd_data[6:0];
                  sda_oe_d = ~reg_if.rd_data[7];
                end else begin
                  state_d  = ST_REG;
                end
              end
              ST_REG_ACK: begin
                state_d = ST_WDATA;
              end
              default: begin
                rd_addr_d = rd_addr_q + 8'd1;
                state_d   = ST_WDATA;
              end
            endcase
          end
        end

        ST_RDATA: begin
          if (scl_rise && bit_cnt_q < c_BITS_PER_BYTE) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == c_BITS_PER_BYTE) begin
            sda_oe_d = 1'b0;
            state_d  = ST_RACK;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            sda_oe_d = ~tx_q[6];
            tx_d     = {tx_q[5:0], 1'b1};
          end
        end

        // The pointer moves on the master's ACK so the reload at the
        // following fall already sees the next register's contents.
        ST_RACK: begin
          if (scl_rise && bit_cnt_q == c_BITS_PER_BYTE) begin
            bit_cnt_d = 4'd0;
            if (sda_s == c_ACK) begin
              rd_addr_d = rd_addr_q + 8'd1;
            end else begin
              state_d = ST_IGNORE;
            end
          end else if (scl_fall && bit_cnt_q == 4'd0) begin
            state_d  = ST_RDATA;
            tx_d     = reg_if.rd_data[6:0];
            sda_oe_d = ~reg_if.rd_data[7];
          end
        end

        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers; reset releases sda and drops any partial byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 7'h00;
      tx_q      <= 7'h00;
      sda_oe_q  <= 1'b0;
      rw_q      <= 1'b0;
      rd_addr_q <= 8'h00;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      sda_oe_q  <= sda_oe_d;
      rw_q      <= rw_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
    end
  end

endmodule : iic_slave_rx
`default_nettype wire
